clock_time_ctrl: RTL

Timekeeping and time-setting controller for the VGA clock face. It counts hours/minutes/seconds from the pixel clock and debounces the hour/minute set buttons with hold-to-repeat stepping. It presents a frame-synchronous time snapshot to the renderer, so digits and hands never change mid-frame. It sits between the top-level pins (`ui_in[7]`, `ui_in[6]`) and the `vga` renderer, and takes the renderer's start-of-frame pulse as its slow timebase.

---
 rtl/clock_time_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/clock_time_ctrl.sv
// Timekeeping core: h/m/s counter off the pixel clock, debounced set buttons with hold-to-repeat, frame-synchronous display snapshot.
// Latency: sec_pulse one clk after prescaler wrap; button step 2 clk sync + DEBOUNCE_FRAMES frame samples; display one frame behind.
// Backpressure: none, free-running; frame_tick is the only pacing input and is assumed to be a single-cycle pulse.
module clock_time_ctrl #(
    parameter int TICKS_PER_SEC   = 25_175_000,
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int HOLD_FRAMES     = 30,
    parameter int REPEAT_FRAMES   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hour_button,
    input  logic       min_button,
    input  logic       frame_tick,
    output logic [4:0] disp_hours,
    output logic [5:0] disp_minutes,
    output logic [5:0] disp_seconds,
    output logic       sec_pulse
);

    localparam int PRE_W = $clog2(TICKS_PER_SEC + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
    localparam int MAX_F = (HOLD_FRAMES > REPEAT_FRAMES) ? HOLD_FRAMES : REPEAT_FRAMES;
    localparam int MAX_C = (MAX_F > DEBOUNCE_FRAMES) ? MAX_F : DEBOUNCE_FRAMES;
    localparam int CNT_W = $clog2(MAX_C + 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_FRAMES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_FRAMES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_REPEAT} btn_state_e;

    // Index 1 is the hour button, index 0 the minute button.
    logic [1:0]       rst_sync_q;
    logic             core_hold;
    logic [1:0]       btn_raw;
    logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d, step;
    logic [CNT_W-1:0] dcnt_q [2];
    logic [CNT_W-1:0] dcnt_d [2];
    logic [CNT_W-1:0] fcnt_q [2];
    logic [CNT_W-1:0] fcnt_d [2];
    btn_state_e       state_q [2];
    btn_state_e       state_d [2];

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             wrap;
    logic [4:0]       hours_q, hours_d, disp_hours_q, disp_hours_d;
    logic [5:0]       min_q, min_d, disp_min_q, disp_min_d;
    logic [5:0]       sec_q, sec_d, disp_sec_q, disp_sec_d;
    logic             sec_pulse_q, sec_pulse_d;

    assign btn_raw   = {hour_button, min_button};
    // Core stays cleared until the second clk edge after rst falls, so release is clean.
    assign core_hold = rst_sync_q[1];
    assign wrap      = (pre_q == PRE_LAST);

    // Reset release synchronizer: asserts with rst, drops out through two flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_sync_q <= 2'b11;
        else     rst_sync_q <= {rst_sync_q[0], 1'b0};
    end

    // Button path: synchronize, debounce on frame samples, then hold/repeat FSM producing steps.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        dcnt_d  = dcnt_q;
        fcnt_d  = fcnt_q;
        state_d = state_q;
        step    = '0;
        if (frame_tick) begin
            for (int b = 0; b < 2; b++) begin
                // A sample equal to the accepted level breaks any pending run.
                if (sync2_q[b] != deb_q[b]) begin
                    if (dcnt_q[b] == DB_LAST) begin
                        deb_d[b]  = sync2_q[b];
                        dcnt_d[b] = '0;
                    end else begin
                        dcnt_d[b] = dcnt_q[b] + 1'b1;
                    end
                end else begin
                    dcnt_d[b] = '0;
                end
                // The FSM reacts to the level accepted on this same frame edge.
                case (state_q[b])
                    ST_IDLE: begin
                        if (deb_d[b] && !deb_q[b]) begin
                            step[b]    = 1'b1;
                            state_d[b] = ST_HELD;
                            fcnt_d[b]  = '0;
                        end
                    end
                    ST_HELD: begin
                        if (!deb_d[b]) begin
                            state_d[b] = ST_IDLE;
                            fcnt_d[b]  = '0;
                        end else if (fcnt_q[b] == HOLD_LAST) begin
                            step[b]    = 1'b1;
                            state_d[b] = ST_REPEAT;
                            fcnt_d[b]  = '0;
                        end else begin
                            fcnt_d[b] = fcnt_q[b] + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (!deb_d[b]) begin
                            state_d[b] = ST_IDLE;
                            fcnt_d[b]  = '0;
                        end else if (fcnt_q[b] == REP_LAST) begin
                            step[b]   = 1'b1;
                            fcnt_d[b] = '0;
                        end else begin
                            fcnt_d[b] = fcnt_q[b] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[b] = ST_IDLE;
                        fcnt_d[b]  = '0;
                    end
                endcase
            end
        end
        if (core_hold) begin
            sync1_d = '0;
            sync2_d = '0;
            deb_d   = '0;
            step    = '0;
            for (int b = 0; b < 2; b++) begin
                dcnt_d[b]  = '0;
                fcnt_d[b]  = '0;
                state_d[b] = ST_IDLE;
            end
        end
    end

    // Time datapath: a set step overrides the seconds carry; snapshot on frame_tick.
    always_comb begin
        pre_d        = pre_q + 1'b1;
        hours_d      = hours_q;
        min_d        = min_q;
        sec_d        = sec_q;
        sec_pulse_d  = wrap;
        disp_hours_d = disp_hours_q;
        disp_min_d   = disp_min_q;
        disp_sec_d   = disp_sec_q;
        if (step != 2'b00) begin
            pre_d = '0;
            sec_d = '0;
            if (step[1]) hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
            if (step[0]) min_d   = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        end else if (wrap) begin
            pre_d = '0;
            if (sec_q == 6'd59) begin
                sec_d = '0;
                if (min_q == 6'd59) begin
                    min_d   = '0;
                    hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
        if (frame_tick) begin
            disp_hours_d = hours_q;
            disp_min_d   = min_q;
            disp_sec_d   = sec_q;
        end
        if (core_hold) begin
            pre_d        = '0;
            hours_d      = '0;
            min_d        = '0;
            sec_d        = '0;
            sec_pulse_d  = 1'b0;
            disp_hours_d = '0;
            disp_min_d   = '0;
            disp_sec_d   = '0;
        end
    end

    // State registers, all cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            for (int b = 0; b < 2; b++) begin
                dcnt_q[b]  <= '0;
                fcnt_q[b]  <= '0;
                state_q[b] <= ST_IDLE;
            end
            pre_q        <= '0;
            hours_q      <= '0;
            min_q        <= '0;
            sec_q        <= '0;
            sec_pulse_q  <= 1'b0;
            disp_hours_q <= '0;
            disp_min_q   <= '0;
            disp_sec_q   <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_q        <= deb_d;
            dcnt_q       <= dcnt_d;
            fcnt_q       <= fcnt_d;
            state_q      <= state_d;
            pre_q        <= pre_d;
            hours_q      <= hours_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            sec_pulse_q  <= sec_pulse_d;
            disp_hours_q <= disp_hours_d;
            disp_min_q   <= disp_min_d;
            disp_sec_q   <= disp_sec_d;
        end
    end

    assign disp_hours   = disp_hours_q;
    assign disp_minutes = disp_min_q;
    assign disp_seconds = disp_sec_q;
    assign sec_pulse    = sec_pulse_q;

endmodule
